// File: rtl/at86rf215_rx_axis_unpacker.sv
// AT86RF215 RX FIFO to AXI4-Stream unpacker: checks I/Q sync framing and sign-extends
// 13-bit samples. Emits fixed-length frames and counts dropped words.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | disabled; FIFO flushed, nothing emitted, errors not counted
// RUN    | streaming samples into frames of FRAME_LEN beats
// FINISH | enable dropped mid-frame; complete the frame, then go IDLE
module at86rf215_rx_axis_unpacker #(
   parameter int unsigned FRAME_LEN     = 1024,
   parameter int unsigned ERR_CNT_WIDTH = 16
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic                     enable,
   input  logic [31:0]              fifo_read_data,
   input  logic                     fifo_empty,
   output logic                     fifo_read_en,
   output logic [31:0]              m_axis_tdata,
   output logic [1:0]               m_axis_tuser,
   output logic                     m_axis_tlast,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic [ERR_CNT_WIDTH-1:0] sync_err_count,
   output logic                     busy
);

   localparam int unsigned IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [IDX_W-1:0]         r_sample_idx;
   logic [31:0]              r_tdata;
   logic [1:0]               r_tuser;
   logic                     r_tlast;
   logic                     r_tvalid;
   logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

   logic w_out_free;
   logic w_word_good;
   logic w_frame_open;
   logic w_active;
   logic w_load;
   logic w_drop;

   assign w_out_free  = !r_tvalid || m_axis_tready;
   assign w_word_good = (fifo_read_data[31:30] == 2'b10) && (fifo_read_data[15:14] == 2'b01);
   assign w_active    = (r_state == S_RUN) || (r_state == S_FINISH);

   // Once enable is gone and the frame is complete (index back at 0), stop popping so the
   // leftover words are flushed by IDLE instead of starting a partial frame.
   assign w_frame_open = ((r_state == S_RUN) && (enable || (r_sample_idx != '0))) ||
                         ((r_state == S_FINISH) && (r_sample_idx != '0));

   always_comb begin
      w_state_nxt  = r_state;
      fifo_read_en = 1'b0;
      case (r_state)
         S_IDLE: begin
            fifo_read_en = !fifo_empty;
            if (enable) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            fifo_read_en = w_frame_open && !fifo_empty && w_out_free;
            if (!enable) begin
               if ((r_sample_idx == '0) && w_out_free) w_state_nxt = S_IDLE;
               else                                   w_state_nxt = S_FINISH;
            end
         end
         S_FINISH: begin
            fifo_read_en = w_frame_open && !fifo_empty && w_out_free;
            // At index 0 any held beat is the tlast beat; leave once it is gone.
            if ((r_sample_idx == '0) && w_out_free) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (!aresetn) fifo_read_en = 1'b0;
   end

   assign w_load = fifo_read_en && w_active && w_word_good;
   assign w_drop = fifo_read_en && w_active && !w_word_good;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state      <= S_IDLE;
         r_sample_idx <= '0;
         r_tdata      <= '0;
         r_tuser      <= '0;
         r_tlast      <= 1'b0;
         r_tvalid     <= 1'b0;
         r_err_cnt    <= '0;
      end else begin
         r_state <= w_state_nxt;

         if (w_load) begin
            r_tdata  <= {{3{fifo_read_data[13]}}, fifo_read_data[13:1],
                         {3{fifo_read_data[29]}}, fifo_read_data[29:17]};
            r_tuser  <= {fifo_read_data[16], fifo_read_data[0]};
            r_tlast  <= (r_sample_idx == IDX_LAST);
            r_tvalid <= 1'b1;
         end else if (m_axis_tready) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
         end

         if (w_load) begin
            r_sample_idx <= (r_sample_idx == IDX_LAST) ? '0 : r_sample_idx + 1'b1;
         end else if (r_state == S_IDLE) begin
            r_sample_idx <= '0;
         end

         if (w_drop && (r_err_cnt != {ERR_CNT_WIDTH{1'b1}})) begin
            r_err_cnt <= r_err_cnt + 1'b1;
         end
      end
   end

   assign m_axis_tdata   = r_tdata;
   assign m_axis_tuser   = r_tuser;
   assign m_axis_tlast   = r_tlast;
   assign m_axis_tvalid  = r_tvalid;
   assign sync_err_count = r_err_cnt;
   assign busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_at86rf215_rx_axis_unpacker.sv
// Bench for the RX unpacker: queue-based FIFO, queue-based expected-beat model, and a
// per-cycle monitor checking AXIS beats, stalls and pop legality.
module tb_at86rf215_rx_axis_unpacker;

   localparam int FL = 4;
   localparam int EW = 16;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic          enable = 1'b0;
   logic [31:0]   fifo_read_data = 32'h0;
   logic          fifo_empty = 1'b1;
   logic          fifo_read_en;
   logic [31:0]   m_axis_tdata;
   logic [1:0]    m_axis_tuser;
   logic          m_axis_tlast;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b0;
   logic [EW-1:0] sync_err_count;
   logic          busy;

   at86rf215_rx_axis_unpacker #(.FRAME_LEN(FL), .ERR_CNT_WIDTH(EW)) dut (
      .aclk           (aclk),
      .aresetn        (aresetn),
      .enable         (enable),
      .fifo_read_data (fifo_read_data),
      .fifo_empty     (fifo_empty),
      .fifo_read_en   (fifo_read_en),
      .m_axis_tdata   (m_axis_tdata),
      .m_axis_tuser   (m_axis_tuser),
      .m_axis_tlast   (m_axis_tlast),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tready  (m_axis_tready),
      .sync_err_count (sync_err_count),
      .busy           (busy)
   );

   always #5 aclk = ~aclk;

   typedef struct packed {
      logic [31:0] d;
      logic [1:0]  u;
      logic        l;
   } beat_t;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] fifo_q[$];
   beat_t       exp_q[$];
   int          model_idx = 0;
   int          model_err = 0;
   bit          pop_now = 1'b0;
   int          ready_mode = 3;

   // monitor bookkeeping
   int          cyc = 0;
   bit          stalled = 1'b0;
   beat_t       prev_beat;
   int          lat_pop = -1, lat_val = -1, hs_first = -1, hs_last = -1;
   int          beat_count = 0;
   logic [31:0] tlast_mask = 0;
   beat_t       first_beat, last_beat;

   function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endfunction

   function automatic void refresh();
      fifo_empty     = (fifo_q.size() == 0);
      fifo_read_data = (fifo_q.size() == 0) ? 32'h0 : fifo_q[0];
   endfunction

   function automatic logic [31:0] make_word(input int iv, input bit ic, input int qv, input bit qc);
      logic [12:0] i13, q13;
      i13 = 13'(iv);
      q13 = 13'(qv);
      return {2'b10, i13, ic, 2'b01, q13, qc};
   endfunction

   // expect_out: the word is consumed while streaming, so it yields a beat or an error count
   function automatic void push_word(input logic [31:0] w, input bit expect_out);
      int    iv, qv;
      beat_t b;
      fifo_q.push_back(w);
      refresh();
      if (expect_out) begin
         if (w[31:30] == 2'b10 && w[15:14] == 2'b01) begin
            iv = int'(w[29:17]);
            qv = int'(w[13:1]);
            if (iv >= 4096) iv -= 8192;
            if (qv >= 4096) qv -= 8192;
            b.d = {16'(qv), 16'(iv)};
            b.u = {w[16], w[0]};
            b.l = ((model_idx % FL) == FL - 1);
            model_idx++;
            exp_q.push_back(b);
         end else if (model_err < 65535) begin
            model_err++;
         end
      end
   endfunction

   function automatic logic [31:0] rand_word(input bit bad);
      logic [31:0] w;
      if (bad) begin
         w = $urandom;
         if (w[31:30] == 2'b10 && w[15:14] == 2'b01) w[31] = 1'b0;
         return w;
      end
      return make_word($urandom_range(0, 8191), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 8191), 1'($urandom_range(0, 1)));
   endfunction

   always @(posedge aclk) begin
      #1;
      if (pop_now) begin
         if (fifo_q.size() > 0) void'(fifo_q.pop_front());
         pop_now = 1'b0;
         refresh();
      end
   end

   always @(posedge aclk) begin
      #2;
      case (ready_mode)
         0:       m_axis_tready = 1'b1;
         1:       m_axis_tready = ~m_axis_tready;
         2:       m_axis_tready = 1'($urandom_range(0, 1));
         default: m_axis_tready = 1'b0;
      endcase
   end

   always @(negedge aclk) begin
      beat_t cur, e;
      cur = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
      cyc++;
      if (!aresetn) begin
         check("rst_read_en", fifo_read_en, 0);
         check("rst_tvalid", m_axis_tvalid, 0);
         pop_now = 1'b0;
         stalled = 1'b0;
      end else begin
         pop_now = fifo_read_en;
         if (fifo_empty) check("no_pop_when_empty", fifo_read_en, 0);
         if (m_axis_tvalid && !m_axis_tready) check("no_pop_while_stalled", fifo_read_en, 0);
         if (stalled) begin
            check("stall_tvalid_held", m_axis_tvalid, 1);
            check("stall_beat_stable", cur, prev_beat);
         end
         if (fifo_read_en && lat_pop < 0) lat_pop = cyc;
         if (m_axis_tvalid && lat_val < 0) lat_val = cyc;
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_beat: got beat %0h expected none", cur);
            end else begin
               e = exp_q.pop_front();
               check("beat_tdata", cur.d, e.d);
               check("beat_tuser", cur.u, e.u);
               check("beat_tlast", cur.l, e.l);
            end
            if (hs_first < 0) hs_first = cyc;
            hs_last = cyc;
            if (beat_count == 0) first_beat = cur;
            last_beat = cur;
            if (beat_count < 32) tlast_mask[beat_count] = m_axis_tlast;
            beat_count++;
         end
         stalled   = m_axis_tvalid && !m_axis_tready;
         prev_beat = cur;
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge aclk);
         #2;
      end
   endtask

   task automatic drain(input string nm, input int budget);
      int n = 0;
      while ((fifo_q.size() != 0 || exp_q.size() != 0 || m_axis_tvalid) && n < budget) begin
         step();
         n++;
      end
      if (n >= budget) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout: got %0d cycles expected fewer than %0d", nm, n, budget);
      end
      check({nm, "_no_loss"}, exp_q.size(), 0);
   endtask

   task automatic clear_marks();
      lat_pop = -1; lat_val = -1; hs_first = -1; hs_last = -1;
      beat_count = 0; tlast_mask = 0;
   endtask

   initial begin
      int pushed, need;
      refresh();
      // reset state, with a word waiting in the FIFO
      fifo_q.push_back(make_word(1, 0, 1, 0));
      refresh();
      step(3);
      check("rst_tvalid_out", m_axis_tvalid, 0);
      check("rst_tlast_out", m_axis_tlast, 0);
      check("rst_tdata_out", m_axis_tdata, 0);
      check("rst_tuser_out", m_axis_tuser, 0);
      check("rst_err_count", sync_err_count, 0);
      check("rst_busy", busy, 0);
      check("rst_no_pop", fifo_read_en, 0);
      fifo_q.delete();
      refresh();
      aresetn = 1'b1;
      step(2);

      // eight good words, I = 1..8, Q = -1
      ready_mode = 0;
      enable = 1'b1;
      step(2);
      check("run_busy", busy, 1);
      clear_marks();
      for (int k = 1; k <= 8; k++) push_word(make_word(k, 0, -1, 0), 1'b1);
      drain("basic", 100);
      check("basic_beats", beat_count, 8);
      check("basic_latency", hs_first - lat_pop, 1);
      check("basic_first_valid", lat_val - lat_pop, 1);
      check("basic_back_to_back", hs_last - hs_first, 7);
      check("basic_tlast_pos", tlast_mask, 32'h88);
      check("basic_first_tdata", first_beat.d, 32'hFFFF_0001);
      check("basic_last_tdata", last_beat.d, 32'hFFFF_0008);

      // 13-bit extremes and control bits
      push_word(make_word(-4096, 1, 4095, 0), 1'b1);
      drain("extreme", 50);
      check("extreme_tdata", last_beat.d, 32'h0FFF_F000);
      check("extreme_tuser", last_beat.u, 2'b10);

      // three bad words mid-frame
      clear_marks();
      push_word(make_word(100, 0, -100, 1), 1'b1);
      for (int k = 0; k < 3; k++) push_word(32'h0, 1'b1);
      push_word(make_word(200, 1, -200, 0), 1'b1);
      push_word(make_word(300, 0, -300, 0), 1'b1);
      drain("bad_sync", 100);
      check("bad_sync_count", sync_err_count, 3);
      check("bad_sync_beats", beat_count, 3);
      check("bad_sync_tlast_pos", tlast_mask, 32'h4);

      // back-pressure: alternating and random tready, FIFO kept about half full
      for (int mode = 1; mode <= 2; mode++) begin
         ready_mode = mode;
         pushed = 0;
         while (pushed < 60) begin
            if (fifo_q.size() < 8) begin
               for (int k = 0; k < $urandom_range(1, 3); k++) begin
                  push_word(rand_word($urandom_range(0, 5) == 0), 1'b1);
                  pushed++;
               end
            end
            step();
         end
         drain("backpressure", 2000);
         check("backpressure_err", sync_err_count, model_err);
      end

      // disable two samples into a frame
      ready_mode = 0;
      need = (FL - (model_idx % FL)) % FL;
      for (int k = 0; k < need; k++) push_word(rand_word(1'b0), 1'b1);
      drain("align", 100);
      push_word(make_word(11, 0, 21, 0), 1'b1);
      push_word(make_word(12, 0, 22, 0), 1'b1);
      drain("pre_finish", 100);
      clear_marks();
      enable = 1'b0;
      step();
      check("finish_busy", busy, 1);
      push_word(make_word(13, 0, 23, 0), 1'b1);
      push_word(make_word(14, 1, 24, 1), 1'b1);
      push_word(32'h0, 1'b0);
      push_word(make_word(15, 0, 25, 0), 1'b0);
      push_word(make_word(16, 0, 26, 0), 1'b0);
      drain("finish", 100);
      step(2);
      check("finish_beats", beat_count, 2);
      check("finish_tlast_pos", tlast_mask, 32'h2);
      check("finish_last_tdata", last_beat.d, 32'h0018_000E);
      check("finish_idle", busy, 0);
      check("finish_err_unchanged", sync_err_count, model_err);

      // enable toggled at a frame boundary returns straight to idle
      enable = 1'b1;
      step(2);
      check("boundary_busy", busy, 1);
      enable = 1'b0;
      step();
      check("boundary_idle", busy, 0);

      // asynchronous reset with a beat held
      enable = 1'b1;
      step(2);
      ready_mode = 3;
      step();
      push_word(make_word(31, 0, 41, 0), 1'b1);
      push_word(make_word(32, 0, 42, 0), 1'b1);
      step(4);
      check("pre_reset_tvalid", m_axis_tvalid, 1);
      aresetn = 1'b0;
      #1;
      check("reset_tvalid", m_axis_tvalid, 0);
      check("reset_tlast", m_axis_tlast, 0);
      check("reset_err", sync_err_count, 0);
      fifo_q.delete();
      exp_q.delete();
      refresh();
      model_idx = 0;
      model_err = 0;
      step(2);
      aresetn = 1'b1;
      ready_mode = 0;
      step(2);
      clear_marks();
      for (int k = 0; k < FL; k++) push_word(make_word(50 + k, 0, -50 - k, 0), 1'b1);
      drain("post_reset", 100);
      check("post_reset_tlast_pos", tlast_mask, 32'h8);

      // saturation of the error counter
      for (int k = 0; k < 65541; k++) push_word(32'h0, 1'b1);
      drain("saturate", 70000);
      check("saturate_count", sync_err_count, 16'hFFFF);
      check("saturate_model", sync_err_count, model_err);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
